// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier sequencer: FSM states, the
// registered strobe bundle and its Moore decode.
package mult_ctrl_pkg;

   localparam int MULT_N = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CALC  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic ld;
      logic clr_p;
      logic calc;
      logic shift;
      logic busy;
      logic done;
   } strobes_t;

   // Decoded from the next state so the registered strobes line up with the state they belong to.
   function automatic strobes_t decode_state(input state_t s);
      strobes_t o;
      o = '0;
      case (s)
         IDLE:    o = '0;
         LOAD:    begin o.ld = 1'b1; o.clr_p = 1'b1; o.busy = 1'b1; end
         CALC:    begin o.calc = 1'b1; o.busy = 1'b1; end
         SHIFT:   begin o.shift = 1'b1; o.busy = 1'b1; end
         DONE:    o.done = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Loadable down-counter for the remaining iteration count; saturates at zero.
// Priority: clr, then load, then dec.
module mult_iter_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rest,
   input  logic         load,
   input  logic         dec,
   input  logic         clr,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         is_one
);

   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = {W{1'b0}};

   logic [W-1:0] r_count;

   // Counter register.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_count <= ZERO;
      end else if (clr) begin
         r_count <= ZERO;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != ZERO)) begin
         r_count <= r_count - ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign count  = r_count;
   assign is_one = (r_count == ONE);

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an N-bit shift-add multiplier datapath (load/clear/add/shift strobes).
// Optional MULT_EARLY_TERM_EN: finish as soon as the B register reads zero in CALC.
module shift_add_mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int N     = MULT_N,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             start,
   input  logic             abort,
   input  logic             b_lsb,
   input  logic             b_zero,
   output logic             ld_a,
   output logic             ld_b,
   output logic             clr_p,
   output logic             add_en,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter
);

   state_t           r_state;
   state_t           w_next;
   strobes_t         r_str;
   logic             w_abort_act;
   logic             w_early;
   logic             w_cnt_clr;
   logic             w_cnt_load;
   logic             w_cnt_dec;
   logic             w_iter_one;
   logic [CNT_W-1:0] w_count;

   assign w_abort_act = abort && (r_state != IDLE);

   // Next-state logic; an active abort overrides every transition.
   always_comb begin
      w_next  = r_state;
      w_early = 1'b0;
      if (w_abort_act) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) w_next = LOAD;
               else       w_next = IDLE;
            end
            LOAD: w_next = CALC;
            CALC: begin
`ifdef MULT_EARLY_TERM_EN
               if (b_zero) begin
                  w_next  = DONE;
                  w_early = 1'b1;
               end else begin
                  w_next  = SHIFT;
               end
`else
               w_next = SHIFT;
`endif
            end
            SHIFT: begin
               if (w_iter_one) w_next = DONE;
               else            w_next = CALC;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Early exit skips the remaining decrements, so the count is cleared to read 0 in DONE.
   assign w_cnt_clr  = w_abort_act || w_early;
   assign w_cnt_load = (r_state == LOAD);
   assign w_cnt_dec  = (r_state == SHIFT);

   mult_iter_cnt #(.W(CNT_W)) u_iter_cnt (
      .clk      (clk),
      .rest     (rest),
      .load     (w_cnt_load),
      .dec      (w_cnt_dec),
      .clr      (w_cnt_clr),
      .load_val (CNT_W'(N)),
      .count    (w_count),
      .is_one   (w_iter_one)
   );

   // State register and registered Moore strobes.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_state <= IDLE;
         r_str   <= '0;
      end else begin
         r_state <= w_next;
         r_str   <= decode_state(w_next);
      end
   end

   assign ld_a     = r_str.ld;
   assign ld_b     = r_str.ld;
   assign clr_p    = r_str.clr_p;
   assign add_en   = r_str.calc & b_lsb & ~b_zero;
   assign shift_en = r_str.shift;
   assign busy     = r_str.busy;
   assign done     = r_str.done;
   assign iter     = w_count;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Table-driven bench for shift_add_mult_ctrl with a behavioural A/B/P datapath model.
// Latency is counted with the cycle in which start is driven as cycle 0.
module tb_shift_add_mult_ctrl;

   logic       clk = 1'b0;
   logic       rest, start, abort, b_lsb, b_zero;
   logic       ld_a, ld_b, clr_p, add_en, shift_en, busy, done;
   logic [3:0] iter;

   logic [7:0]  a_in, b_in, m_b;
   logic [15:0] m_a, m_p;

   int n_pass = 0;
   int n_total = 0;
   int n_viol = 0;

`ifdef MULT_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   shift_add_mult_ctrl dut (
      .clk(clk), .rest(rest), .start(start), .abort(abort),
      .b_lsb(b_lsb), .b_zero(b_zero),
      .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .add_en(add_en),
      .shift_en(shift_en), .busy(busy), .done(done), .iter(iter)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_a) m_a <= {8'd0, a_in};
      else if (shift_en) m_a <= m_a << 1;
      if (ld_b) m_b <= b_in;
      else if (shift_en) m_b <= m_b >> 1;
      if (clr_p) m_p <= 16'd0;
      else if (add_en) m_p <= m_p + m_a;
   end
   assign b_lsb  = m_b[0];
   assign b_zero = (m_b == 8'd0);

   always @(negedge clk) begin
      if (add_en && shift_en) n_viol <= n_viol + 1;
      if ((ld_a || ld_b || clr_p) && !(ld_a && ld_b && clr_p && busy)) n_viol <= n_viol + 1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit inject,
                         output int lat, output int n_ld, output int n_sh, output int mask);
      @(negedge clk);
      a_in = a; b_in = b; start = 1'b1;
      lat = -1; n_ld = 0; n_sh = 0; mask = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ld_a) n_ld++;
         if (add_en) mask = mask | (1 << n_sh);
         if (shift_en) n_sh++;
         if (done) begin lat = i; break; end
         start = inject ? busy : 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic quiet(input int n, output int nd, output int nl);
      nd = 0; nl = 0;
      repeat (n) begin
         @(negedge clk);
         if (done) nd++;
         if (ld_a) nl++;
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          lat_full;
      int          lat_early;
      int          sh_early;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int lat, n_ld, n_sh, mask, nd, nl, d1, d2, exp_lat;
      bit found;

      vecs[0] = '{8'd13,  8'd11,  16'd143,   18, 11, 4};
      vecs[1] = '{8'd255, 8'd255, 16'd65025, 18, 18, 8};
      vecs[2] = '{8'd0,   8'd0,   16'd0,     18, 3,  0};
      vecs[3] = '{8'd1,   8'd128, 16'd128,   18, 18, 8};
      vecs[4] = '{8'd200, 8'd1,   16'd200,   18, 5,  1};
      vecs[5] = '{8'd170, 8'd85,  16'd14450, 18, 17, 7};

      rest = 1'b0; start = 1'b0; abort = 1'b0; a_in = 8'd0; b_in = 8'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {ld_a, ld_b, clr_p, add_en, shift_en, busy, done, iter}, 0);
      rest = 1'b1;

      // abort alone in IDLE does nothing; abort together with start lets start win
      abort = 1'b1;
      @(negedge clk);
      chk("abort_in_idle", {busy, ld_a, done}, 0);
      a_in = 8'd2; b_in = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_beats_abort", {ld_a, busy}, 2'b11);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin found = 1'b1; break; end
      end
      chk("start_beats_abort_done", found, 1);
      chk("start_beats_abort_p", m_p, 6);

      for (int v = 0; v < 6; v++) begin
         exp_lat = EARLY ? vecs[v].lat_early : vecs[v].lat_full;
         run_op(vecs[v].a, vecs[v].b, 1'b0, lat, n_ld, n_sh, mask);
         chk($sformatf("vec%0d_latency", v), lat, exp_lat);
         chk($sformatf("vec%0d_product", v), m_p, vecs[v].p);
         chk($sformatf("vec%0d_loads", v), n_ld, 1);
         chk($sformatf("vec%0d_shifts", v), n_sh, EARLY ? vecs[v].sh_early : 8);
         chk($sformatf("vec%0d_add_mask", v), mask, vecs[v].b);
         chk($sformatf("vec%0d_done_iter", v), iter, 0);
      end

      // abort when iter reads 4, then a clean 255*255
      @(negedge clk);
      a_in = 8'd255; b_in = 8'd255; start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (iter == 4'd4) begin found = 1'b1; break; end
      end
      chk("abort_reached_iter4", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_to_idle", {busy, done, ld_a, shift_en, iter}, 0);
      quiet(25, nd, nl);
      chk("abort_no_done", nd, 0);
      run_op(8'd255, 8'd255, 1'b0, lat, n_ld, n_sh, mask);
      chk("post_abort_latency", lat, 18);
      chk("post_abort_product", m_p, 65025);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      a_in = 8'd9; b_in = 8'd255; start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy && !shift_en && !ld_a && iter == 4'd6) begin found = 1'b1; break; end
      end
      chk("reset_reached_calc", found, 1);
      #2 rest = 1'b0;
      #1 chk("reset_mid_calc", {busy, done, add_en, shift_en, ld_a, iter}, 0);
      @(negedge clk);
      rest = 1'b1;
      @(negedge clk);
      chk("after_reset_idle", {busy, done, iter}, 0);

      // start held high: back-to-back ops, done pulses 19 cycles apart
      @(negedge clk);
      a_in = 8'd3; b_in = 8'd255; start = 1'b1;
      d1 = -1; d2 = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            if (d1 < 0) d1 = i;
            else if (d2 < 0) d2 = i;
         end
      end
      start = 1'b0;
      chk("held_first_done", d1, 18);
      chk("held_done_spacing", d2 - d1, 19);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin found = 1'b1; break; end
      end
      chk("held_drain_done", found, 1);
      @(negedge clk);

      // start injected every busy cycle: ignored, a single done
      run_op(8'd13, 8'd11, 1'b1, lat, n_ld, n_sh, mask);
      quiet(25, nd, nl);
      chk("inject_latency", lat, EARLY ? 11 : 18);
      chk("inject_product", m_p, 143);
      chk("inject_loads", n_ld, 1);
      chk("inject_extra_done", nd, 0);
      chk("inject_extra_load", nl, 0);

      chk("strobe_exclusivity", n_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
